fft_peak_detect: RTL and testbench
==================================

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 12, FFT sample width per component.
REQ-002 SHALL have parameter LOG2_N, default 6, log2 of FFT length N (64 bins).
REQ-003 SHALL have parameter MAG_WIDTH, default 2*WIDTH+2, width of incoming magnitude-squared word.
REQ-004 SHALL have parameter SKIP_BINS, default 1, count of lowest bins excluded from the search (DC suppression).
REQ-005 SHALL have parameter HALF_ONLY, default 1; 1 = search bins below N/2 only (real-input symmetry).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 ce  input  1  sample strobe, same cadence as the FFT clock enable; one bin per ce cycle.
REQ-009 sync  input  1  qualified by ce; marks bin 0 of a frame.
REQ-010 mag  input  MAG_WIDTH  unsigned magnitude-squared of current bin.
REQ-011 peak_bin  output  LOG2_N  bin index of frame maximum.
REQ-012 peak_mag  output  MAG_WIDTH  magnitude of frame maximum.
REQ-013 peak_valid  output  1  one-cycle pulse: new peak_bin/peak_mag reported.
REQ-014 frame_err  output  1  one-cycle pulse: framing violation detected.

Function
REQ-015 SHALL implement states WAIT_SYNC and SCAN; cycles with ce=0 SHALL change no state, counter or running maximum.
REQ-016 In WAIT_SYNC, ce&&sync SHALL set bin counter to 0, process that sample as bin 0, enter SCAN; ce without sync SHALL be ignored.
REQ-017 In SCAN, each ce cycle SHALL process mag as bin = counter value, then increment counter modulo N.
REQ-018 Candidate bins: SKIP_BINS <= bin < LIMIT, LIMIT = N/2 if HALF_ONLY else N; other bins SHALL not affect the maximum.
REQ-019 First candidate of a frame SHALL load the running maximum unconditionally; later candidates replace it only if mag strictly greater (ties keep lowest bin).
REQ-020 On processing bin N-1, SHALL register running max and its bin to peak_mag/peak_bin and pulse peak_valid on the following cycle (latency 1 clk after last-bin ce).
REQ-021 After bin N-1, state SHALL stay SCAN; next ce sample SHALL carry sync (back-to-back frames).
REQ-022 Expected bin 0 without sync: SHALL pulse frame_err, discard sample, go to WAIT_SYNC.
REQ-023 sync at expected bin != 0: SHALL pulse frame_err, discard partial frame (no peak_valid), restart as bin 0 with this sample.
REQ-024 frame_err and peak_valid SHALL both be registered, 1 clk after triggering ce cycle; simultaneous assertion impossible by construction.
REQ-025 peak_bin/peak_mag SHALL hold last reported values until next report.
REQ-026 Magnitude comparison SHALL be unsigned, full MAG_WIDTH, no truncation.

Reset
REQ-027 reset=0 at a clock edge SHALL force WAIT_SYNC, counter 0, running max 0, peak_bin 0, peak_mag 0, peak_valid 0, frame_err 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no peak_valid or frame_err; reset has priority over ce.

Structure
REQ-029 Shared package fft_pkg SHALL hold WIDTH, LOG2_N, MAG_WIDTH defaults and the state enum type.
REQ-030 SHALL be a single module; no sub-module (comparator and counter inline).

Verification
REQ-031 Frame N=64, ce=1, mag=bin*2 except bin 20 = 5000 -> one peak_valid 1 clk after bin 63, peak_bin=20, peak_mag=5000, frame_err=0.
REQ-032 Bin 0 = 0xFFFFFF, bin 40 = 9999, others 1 (SKIP_BINS=1, HALF_ONLY=1) -> peak_bin=1, peak_mag=1 (bin 0 and 40 excluded).
REQ-033 Equal mag=77 at bins 5 and 9, others 0 -> peak_bin=5, peak_mag=77.
REQ-034 ce toggling 1/0 every cycle over a full frame -> same result as REQ-031, peak_valid 1 clk after 64th ce.
REQ-035 sync reasserted at bin 30 -> frame_err pulse, no peak_valid for that frame; next full frame reports correctly; missing sync at frame boundary -> frame_err, WAIT_SYNC until next sync.
REQ-036 reset=0 for one cycle at bin 50 -> all outputs 0, no peak_valid; next sync starts clean frame reported correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT post-processing blocks.
package fft_pkg;

  localparam int unsigned DEF_WIDTH     = 12;
  localparam int unsigned DEF_LOG2_N    = 6;
  localparam int unsigned DEF_MAG_WIDTH = 2 * DEF_WIDTH + 2;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    SCAN      = 1'b1
  } state_t;

endpackage

// File: rtl/fft_peak_detect.sv
// Tracks the largest magnitude-squared bin of each FFT output frame and reports
// it one clock after the last bin; framing errors are flagged and the frame dropped.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LOG2_N    = DEF_LOG2_N,
  parameter int unsigned MAG_WIDTH = 2 * WIDTH + 2,
  parameter int unsigned SKIP_BINS = 1,
  parameter bit          HALF_ONLY = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 sync,
  input  logic [MAG_WIDTH-1:0] mag,
  output logic [LOG2_N-1:0]    peak_bin,
  output logic [MAG_WIDTH-1:0] peak_mag,
  output logic                 peak_valid,
  output logic                 frame_err
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned LIMIT = HALF_ONLY ? N / 2 : N;
  localparam int unsigned BW    = LOG2_N + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LOG2_N-1:0]     r_cnt;
  logic [MAG_WIDTH-1:0]  r_max;
  logic [LOG2_N-1:0]     r_max_bin;
  logic                  r_have;
  logic [LOG2_N-1:0]     r_peak_bin;
  logic [MAG_WIDTH-1:0]  r_peak_mag;
  logic                  r_peak_valid;
  logic                  r_frame_err;

  logic                  w_proc;
  logic                  w_restart;
  logic                  w_err;
  logic [LOG2_N-1:0]     w_bin;
  logic                  w_have_base;
  logic [MAG_WIDTH-1:0]  w_max_base;
  logic [LOG2_N-1:0]     w_max_bin_base;
  logic                  w_cand;
  logic                  w_take;
  logic                  w_last;
  logic [MAG_WIDTH-1:0]  w_max_nxt;
  logic [LOG2_N-1:0]     w_max_bin_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= WAIT_SYNC;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (ce) begin
      case (r_state)
        WAIT_SYNC: if (sync) w_state_nxt = SCAN;
        SCAN:      if (r_cnt == '0 && !sync) w_state_nxt = WAIT_SYNC;
        default:   w_state_nxt = WAIT_SYNC;
      endcase
    end
  end

  // Per-sample decode: which bin this sample is, whether it opens a frame, framing errors
  always_comb begin
    w_proc    = 1'b0;
    w_restart = 1'b0;
    w_err     = 1'b0;
    w_bin     = r_cnt;
    if (ce) begin
      case (r_state)
        WAIT_SYNC: begin
          if (sync) begin
            w_proc    = 1'b1;
            w_restart = 1'b1;
            w_bin     = '0;
          end
        end
        SCAN: begin
          if (r_cnt == '0) begin
            if (sync) begin
              w_proc    = 1'b1;
              w_restart = 1'b1;
            end else begin
              w_err     = 1'b1;
            end
          end else if (sync) begin
            w_err     = 1'b1;
            w_proc    = 1'b1;
            w_restart = 1'b1;
            w_bin     = '0;
          end else begin
            w_proc    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Running maximum update; a new frame starts from an empty maximum
  always_comb begin
    w_have_base    = w_restart ? 1'b0 : r_have;
    w_max_base     = w_restart ? '0 : r_max;
    w_max_bin_base = w_restart ? '0 : r_max_bin;
    w_cand         = w_proc && ({1'b0, w_bin} >= BW'(SKIP_BINS))
                            && ({1'b0, w_bin} <  BW'(LIMIT));
    w_take         = w_cand && (!w_have_base || (mag > w_max_base));
    w_max_nxt      = w_take ? mag   : w_max_base;
    w_max_bin_nxt  = w_take ? w_bin : w_max_bin_base;
    w_last         = w_proc && (&w_bin);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_max        <= '0;
      r_max_bin    <= '0;
      r_have       <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_peak_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_peak_valid <= w_last;
      r_frame_err  <= w_err;
      if (w_proc) begin
        r_cnt     <= w_bin + LOG2_N'(1);
        r_max     <= w_max_nxt;
        r_max_bin <= w_max_bin_nxt;
        r_have    <= w_have_base | w_cand;
      end
      if (w_last) begin
        r_peak_bin <= w_max_bin_nxt;
        r_peak_mag <= w_max_nxt;
      end
    end
  end

  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
  assign peak_valid = r_peak_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with default parameters (N=64, bins 1..31 searched).
module tb_fft_peak_detect;

  localparam int unsigned MW = 26;
  localparam int unsigned BW = 6;

  logic          clk;
  logic          reset;
  logic          ce;
  logic          sync;
  logic [MW-1:0] mag;
  logic [BW-1:0] peak_bin;
  logic [MW-1:0] peak_mag;
  logic          peak_valid;
  logic          frame_err;

  int checks;
  int failures;
  int n_pv;
  int n_fe;
  logic [MW-1:0] fr [64];

  fft_peak_detect dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .sync       (sync),
    .mag        (mag),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_valid (peak_valid),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (peak_valid) n_pv = n_pv + 1;
    if (frame_err)  n_fe = n_fe + 1;
  end

  task automatic build_frame(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: fr[i] = (i == 20) ? MW'(5000) : MW'(i * 2);
        1: fr[i] = (i == 0) ? MW'(24'hFFFFFF) : ((i == 40) ? MW'(9999) : MW'(1));
        2: fr[i] = (i == 5 || i == 9) ? MW'(77) : MW'(0);
        3: fr[i] = (i == 7) ? MW'(26'h3FFFFFF) : ((i == 8) ? MW'(26'h2000000) : MW'(3));
        default: fr[i] = (i == 31) ? MW'(100) : ((i == 32) ? MW'(200) : MW'(0));
      endcase
    end
  endtask

  task automatic send(input logic s, input logic [MW-1:0] m);
    @(negedge clk);
    ce = 1'b1; sync = s; mag = m;
  endtask

  task automatic idle();
    @(negedge clk);
    ce = 1'b0; sync = 1'b0;
  endtask

  task automatic send_frame(input bit toggle);
    for (int i = 0; i < 64; i++) begin
      send(i == 0, fr[i]);
      if (toggle && i != 63) idle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ce = 1'b0; sync = 1'b0; mag = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b0 || frame_err !== 1'b0 || peak_bin !== '0 || peak_mag !== '0) begin
      failures++;
      $display("FAIL reset_outputs got pv=%0b fe=%0b bin=%0d mag=%0d want all 0",
               peak_valid, frame_err, peak_bin, peak_mag);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pattern(input int kind, input bit toggle, input logic [BW-1:0] exp_bin,
                              input logic [MW-1:0] exp_mag, input string name);
    int pv0, fe0;
    pv0 = n_pv; fe0 = n_fe;
    build_frame(kind);
    send_frame(toggle);
    @(posedge clk); #1;
    ce = 1'b0;
    checks++;
    if (peak_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid got %0b want 1", name, peak_valid);
    end
    checks++;
    if (peak_bin !== exp_bin || peak_mag !== exp_mag) begin
      failures++;
      $display("FAIL %s_peak got bin=%0d mag=%0d want bin=%0d mag=%0d",
               name, peak_bin, peak_mag, exp_bin, exp_mag);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (peak_valid !== 1'b0 || peak_bin !== exp_bin || peak_mag !== exp_mag) begin
      failures++;
      $display("FAIL %s_hold got pv=%0b bin=%0d mag=%0d want pv=0 bin=%0d mag=%0d",
               name, peak_valid, peak_bin, peak_mag, exp_bin, exp_mag);
    end
    checks++;
    if (n_pv - pv0 !== 1 || n_fe - fe0 !== 0) begin
      failures++;
      $display("FAIL %s_pulses got pv=%0d fe=%0d want pv=1 fe=0", name, n_pv - pv0, n_fe - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int pv0;
    pv0 = n_pv;
    build_frame(4);
    send_frame(1'b0);
    @(posedge clk); #1;
    checks++;
    if (peak_valid !== 1'b1 || peak_bin !== 6'd31 || peak_mag !== MW'(100)) begin
      failures++;
      $display("FAIL b2b_first got pv=%0b bin=%0d mag=%0d want pv=1 bin=31 mag=100",
               peak_valid, peak_bin, peak_mag);
    end
    build_frame(0);
    send_frame(1'b0);
    @(posedge clk); #1;
    ce = 1'b0;
    checks++;
    if (peak_valid !== 1'b1 || peak_bin !== 6'd20 || peak_mag !== MW'(5000)) begin
      failures++;
      $display("FAIL b2b_second got pv=%0b bin=%0d mag=%0d want pv=1 bin=20 mag=5000",
               peak_valid, peak_bin, peak_mag);
    end
    @(posedge clk); #1;
    checks++;
    if (n_pv - pv0 !== 2 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count got pv=%0d fe=%0b want pv=2 fe=0", n_pv - pv0, frame_err);
    end
  endtask

  task automatic test_resync();
    int pv0;
    pv0 = n_pv;
    build_frame(2);
    fr[10] = MW'(9000);
    for (int i = 0; i < 30; i++) send(i == 0, fr[i]);
    build_frame(0);
    send(1'b1, fr[0]);
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b1 || peak_valid !== 1'b0) begin
      failures++;
      $display("FAIL resync_err got fe=%0b pv=%0b want fe=1 pv=0", frame_err, peak_valid);
    end
    for (int i = 1; i < 64; i++) send(1'b0, fr[i]);
    @(posedge clk); #1;
    ce = 1'b0;
    checks++;
    if (peak_valid !== 1'b1 || peak_bin !== 6'd20 || peak_mag !== MW'(5000) || n_pv - pv0 !== 0) begin
      failures++;
      $display("FAIL resync_next got pv=%0b bin=%0d mag=%0d early=%0d want pv=1 bin=20 mag=5000 early=0",
               peak_valid, peak_bin, peak_mag, n_pv - pv0);
    end
  endtask

  task automatic test_missing_sync();
    int fe0, pv0;
    @(posedge clk); #1;
    fe0 = n_fe; pv0 = n_pv;
    send(1'b0, MW'(12345));
    @(posedge clk); #1;
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL nosync_err got %0b want 1", frame_err);
    end
    for (int i = 0; i < 70; i++) send(1'b0, MW'(500));
    idle();
    @(posedge clk); #1;
    checks++;
    if (n_fe - fe0 !== 1 || n_pv - pv0 !== 0) begin
      failures++;
      $display("FAIL nosync_ignored got fe=%0d pv=%0d want fe=1 pv=0", n_fe - fe0, n_pv - pv0);
    end
    test_pattern(2, 1'b0, 6'd5, MW'(77), "nosync_recover");
  endtask

  task automatic test_reset_midframe();
    int pv0, fe0;
    build_frame(0);
    for (int i = 0; i < 50; i++) send(i == 0, fr[i]);
    pv0 = n_pv; fe0 = n_fe;
    @(negedge clk);
    reset = 1'b0; ce = 1'b1; sync = 1'b0; mag = fr[50];
    @(posedge clk); #1;
    checks++;
    if (peak_valid !== 1'b0 || frame_err !== 1'b0 || peak_bin !== '0 || peak_mag !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got pv=%0b fe=%0b bin=%0d mag=%0d want all 0",
               peak_valid, frame_err, peak_bin, peak_mag);
    end
    reset = 1'b1; ce = 1'b0;
    for (int i = 51; i < 64; i++) send(1'b0, fr[i]);
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n_pv - pv0 !== 0 || n_fe - fe0 !== 0) begin
      failures++;
      $display("FAIL midreset_quiet got pv=%0d fe=%0d want 0 0", n_pv - pv0, n_fe - fe0);
    end
    test_pattern(2, 1'b0, 6'd5, MW'(77), "midreset_recover");
  endtask

  initial begin
    checks = 0; failures = 0; n_pv = 0; n_fe = 0;
    test_reset();
    test_pattern(0, 1'b0, 6'd20, MW'(5000), "basic");
    test_pattern(1, 1'b0, 6'd1,  MW'(1),    "dc_skip");
    test_pattern(2, 1'b0, 6'd5,  MW'(77),   "tie");
    test_pattern(0, 1'b1, 6'd20, MW'(5000), "ce_toggle");
    test_pattern(3, 1'b0, 6'd7,  MW'(26'h3FFFFFF), "full_width");
    test_pattern(4, 1'b0, 6'd31, MW'(100),  "half_edge");
    test_back_to_back();
    test_resync();
    test_missing_sync();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
